multi_tick_gen: RTL and testbench
=================================

Name: multi_tick_gen

Overview:
- Parametrised successor to the single-rate 1 Hz divider.
- Runs one shared prescaler from the system clock to a base tick (default 1 kHz). Feeds NUM_CH independent programmable channel dividers.
- Each channel gives a one-cycle tick pulse and a near-50% square wave.
- The traffic controller uses it for phase timers (1 Hz), lamp blink (2 Hz) and the pedestrian beeper, all from one block with runtime-changeable rates.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BASE_HZ, 1000, prescaler output rate. CLK_HZ/BASE_HZ must be an integer >= 2.
- NUM_CH, 4, number of channel dividers.
- DIV_W, 16, divisor width in bits.
- DEF_DIV, 1000, divisor loaded into every channel at reset (1 Hz at defaults).

Ports:
- clk_100MHz  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global run. Low freezes the prescaler.
- sync_clr  in  1  synchronous restart of all counters (phase alignment)
- ch_en  in  NUM_CH  per-channel run enable
- div_load  in  NUM_CH  per-channel one-cycle strobe to capture the divisor
- div_val  in  NUM_CH*DIV_W  packed divisors; channel i is bits [i*DIV_W +: DIV_W]
- base_tick  out  1  one-cycle pulse at BASE_HZ
- tick  out  NUM_CH  one-cycle pulse per channel period
- sq  out  NUM_CH  square wave per channel

Behaviour:
- Reset values (reset_n low, asynchronous):
  - prescaler count 0; all channel counts 0.
  - active and shadow divisors = DEF_DIV.
  - base_tick, tick, sq all 0.
- Prescaler, with PRESCALE = CLK_HZ/BASE_HZ:
  - When enable is high, counts 0..PRESCALE-1 and wraps.
  - base_tick is registered. It is high for the one cycle after the count equals PRESCALE-1.
  - First base_tick appears PRESCALE cycles after reset release with enable held high.
  - enable low: count holds, base_tick is 0, all channels freeze.
- Channel i advances only on cycles where base_tick_int (the prescaler wrap strobe) and ch_en[i] are both high:
  - If cnt == active-1: cnt goes to 0, and tick[i] is high the next cycle (same cycle as base_tick).
  - Otherwise cnt increments.
  - tick[i] is 0 in all other cycles.
- Channel square wave:
  - half = ceil(active/2).
  - On every advance, sq[i] <= (next_cnt < half).
  - sq[i] holds between advances and while the channel is disabled.
  - Odd divisor: high for ceil, low for floor base ticks.
  - Divisor 1: tick on every advance, sq constantly 1 after the first advance.
- Divisor update:
  - div_load[i] captures div_val slice i into shadow[i]. A value of 0 is clamped to 1.
  - active[i] <= shadow[i] only at a period wrap (cnt wraps to 0), so no glitch or shortened period.
  - div_load in the same cycle as a wrap: the newly loaded value goes directly to active.
  - Repeated loads before a wrap: last one wins.
- ch_en[i] low: cnt, sq and shadow hold; tick[i] is 0; div_load is still accepted.
- sync_clr:
  - Takes priority over enable, base tick and advances.
  - Next cycle: prescaler 0, all cnt 0, tick 0, sq 0, active[i] <= shadow[i] (or the clamped div_val if div_load is coincident).
- Counts never exceed active-1. If active shrinks below the current cnt, that cannot happen because the transfer only occurs at a wrap.
- Width rules:
  - Prescaler width is $clog2(PRESCALE).
  - Channel cnt width is DIV_W; all compares are unsigned at DIV_W.

Decomposition:
- Package tick_gen_pkg:
  - function clog2_safe (returns >= 1).
  - localparam helpers for PRESCALE width.
  - constant DIV_MIN = 1.
- Sub-module tick_channel (one instance per channel, via generate) holds shadow, active, cnt, tick and sq.
- The prescaler stays in the top level.

Test Plan:
All scenarios use CLK_HZ=100, BASE_HZ=10 (PRESCALE=10), NUM_CH=2, DIV_W=8, DEF_DIV=4.
- Reset release, enable=1, ch_en=11:
  - base_tick at cycles 10, 20, 30…
  - tick[0] first at cycle 40, then every 40 cycles.
  - sq[0] high for 20 cycles, then low for 20.
- Load divisor 3 on ch1 mid-period (cycle 25):
  - Current period still ends at cycle 40.
  - Then tick[1] every 30 cycles; sq[1] high 20, low 10.
- div_val=0 with load on ch0:
  - After the next wrap, tick[0] coincides with every base_tick; sq[0] stays 1.
- ch_en[0]=0 for 25 cycles mid-period:
  - tick[0] is suppressed; the period resumes at the held count; sq[0] is frozen.
- enable=0 for 15 cycles:
  - base_tick and all ticks stop.
  - After re-enable, the first base_tick arrives after the remaining prescaler count.
- sync_clr at cycle 37, concurrent with div_load ch0=2:
  - All outputs 0 at cycle 38.
  - Next base_tick at cycle 48; tick[0] at cycle 58.
- Assert reset_n low mid-period:
  - All outputs 0 immediately (asynchronous).
  - Divisors return to 4.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared constants and width helpers for the multi-rate tick generator.
// Imported by the top level and the channel divider.
package tick_gen_pkg;

  localparam int DIV_MIN = 1;

  function automatic int clog2_safe(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int prescale_of(
    input int clk_hz,
    input int base_hz
  );
    return clk_hz / base_hz;
  endfunction

  function automatic int prescale_w(
    input int clk_hz,
    input int base_hz
  );
    return clog2_safe(prescale_of(clk_hz, base_hz));
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable divider channel clocked by the shared base tick.
// Divisor changes are staged in a shadow and applied only at a wrap.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_adv,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_val,
  output logic             o_tick,
  output logic             o_sq
);

  logic [DIV_W-1:0] r_shadow;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_sq;

  logic [DIV_W-1:0] w_val;
  logic [DIV_W-1:0] w_next;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_xfer;
  logic             w_last;

  assign w_val  = (i_val == '0) ? DIV_W'(DIV_MIN) : i_val;
  assign w_last = (r_cnt == r_active - DIV_W'(1));
  assign w_next = w_last ? '0 : r_cnt + DIV_W'(1);
  assign w_half = (r_active >> 1) + DIV_W'(r_active[0]);
  assign w_xfer = i_load ? w_val : r_shadow;

  // Shadow divisor: latest load wins, accepted even while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= DIV_W'(DEF_DIV);
    end else if (i_load) begin
      r_shadow <= w_val;
    end
  end

  // Active divisor, count, tick and square wave.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= DIV_W'(DEF_DIV);
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_sq     <= 1'b0;
    end else if (i_clr) begin
      r_active <= w_xfer;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_sq     <= 1'b0;
    end else begin
      r_tick <= i_adv & w_last;
      if (i_adv) begin
        r_cnt <= w_next;
        r_sq  <= (w_next < w_half);
        if (w_last) begin
          r_active <= w_xfer;
        end
      end
    end
  end

  assign o_tick = r_tick;
  assign o_sq   = r_sq;

endmodule

// File: rtl/multi_tick_gen.sv
// Shared prescaler to a base tick feeding NUM_CH programmable dividers.
// Each channel emits a one-cycle tick and a near-50% square wave.
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BASE_HZ = 1000,
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1000
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sync_clr,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq
);

  localparam int PRESCALE = prescale_of(CLK_HZ, BASE_HZ);
  localparam int PW       = prescale_w(CLK_HZ, BASE_HZ);

  if (PRESCALE < 2) begin : g_bad_rate
    $error("CLK_HZ/BASE_HZ must be at least 2");
  end

  logic [PW-1:0] r_pcnt;
  logic          r_base;
  logic          w_wrap;

  assign w_wrap = enable & (r_pcnt == PW'(PRESCALE - 1));

  // Prescaler: free-runs while enabled, restarts on sync_clr.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt <= '0;
      r_base <= 1'b0;
    end else if (sync_clr) begin
      r_pcnt <= '0;
      r_base <= 1'b0;
    end else begin
      r_base <= w_wrap;
      if (enable) begin
        r_pcnt <= w_wrap ? '0 : r_pcnt + PW'(1);
      end
    end
  end

  assign base_tick = r_base;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .i_clk   (clk_100MHz),
      .i_rst_n (reset_n),
      .i_clr   (sync_clr),
      .i_adv   (w_wrap & ch_en[g]),
      .i_load  (div_load[g]),
      .i_val   (div_val[g*DIV_W +: DIV_W]),
      .o_tick  (tick[g]),
      .o_sq    (sq[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: directed scenarios plus random traffic,
// each cycle compared against a period-level reference model.
module tb_multi_tick_gen;

  localparam int PRE = 10;
  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int DEF = 4;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          sync_clr;
  logic [1:0]    ch_en;
  logic [1:0]    div_load;
  logic [15:0]   div_val;
  logic          base_tick;
  logic [1:0]    tick;
  logic [1:0]    sq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   m_pc;
  int   m_pos [NCH];
  int   m_act [NCH];
  int   m_sh  [NCH];
  logic       m_base;
  logic [1:0] m_tick;
  logic [1:0] m_sq;

  multi_tick_gen #(
    .CLK_HZ  (100),
    .BASE_HZ (10),
    .NUM_CH  (NCH),
    .DIV_W   (DW),
    .DEF_DIV (DEF)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .sync_clr   (sync_clr),
    .ch_en      (ch_en),
    .div_load   (div_load),
    .div_val    (div_val),
    .base_tick  (base_tick),
    .tick       (tick),
    .sq         (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc   = 0;
    m_base = 1'b0;
    m_tick = '0;
    m_sq   = '0;
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = 0;
      m_act[i] = DEF;
      m_sh[i]  = DEF;
    end
  endfunction

  // One base period position per channel; a period lasts m_act base ticks.
  function automatic void model_update();
    bit strobe;
    int v;
    strobe = enable && (m_pc == PRE - 1);
    for (int i = 0; i < NCH; i++) begin
      if (div_load[i]) begin
        v = int'(div_val[i*DW +: DW]);
        m_sh[i] = (v == 0) ? 1 : v;
      end
    end
    if (sync_clr) begin
      m_pc   = 0;
      m_base = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_pos[i]  = 0;
        m_act[i]  = m_sh[i];
        m_tick[i] = 1'b0;
        m_sq[i]   = 1'b0;
      end
    end else begin
      m_base = strobe;
      if (enable) m_pc = (m_pc + 1) % PRE;
      for (int i = 0; i < NCH; i++) begin
        m_tick[i] = 1'b0;
        if (strobe && ch_en[i]) begin
          if (m_pos[i] == m_act[i] - 1) begin
            m_pos[i]  = 0;
            m_tick[i] = 1'b1;
            m_act[i]  = m_sh[i];
          end else begin
            m_pos[i]++;
          end
          m_sq[i] = (m_pos[i] < (m_act[i] + 1) / 2);
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic set_idle();
    enable   = 1'b1;
    sync_clr = 1'b0;
    ch_en    = 2'b11;
    div_load = 2'b00;
    div_val  = '0;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({base_tick, tick, sq} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 00000", {base_tick, tick, sq});
    end
    do_reset();
    checks++;
    if ({base_tick, tick, sq} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release got %b want 00000", {base_tick, tick, sq});
    end
  endtask

  task automatic test_default();
    logic exp;
    set_idle();
    do_reset();
    while (cyc < 100) begin
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL default_model cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
      checks++;
      if (base_tick !== (cyc % 10 == 0)) begin
        errors++;
        $display("FAIL default_base cyc %0d got %b", cyc, base_tick);
      end
      checks++;
      if (tick[0] !== (cyc % 40 == 0)) begin
        errors++;
        $display("FAIL default_tick0 cyc %0d got %b", cyc, tick[0]);
      end
      if (cyc >= 40 && cyc < 80) begin
        exp = (cyc < 60);
        checks++;
        if (sq[0] !== exp) begin
          errors++;
          $display("FAIL default_sq0 cyc %0d got %b want %b", cyc, sq[0], exp);
        end
      end
    end
  endtask

  task automatic test_load_mid();
    logic exp;
    set_idle();
    do_reset();
    while (cyc < 135) begin
      if (cyc == 24) begin
        div_val[15:8] = 8'd3;
        div_load      = 2'b10;
      end else begin
        div_load = 2'b00;
      end
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL load_model cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
      exp = (cyc == 40) || (cyc > 40 && (cyc - 40) % 30 == 0);
      checks++;
      if (tick[1] !== exp) begin
        errors++;
        $display("FAIL load_tick1 cyc %0d got %b want %b", cyc, tick[1], exp);
      end
      if (cyc >= 70 && cyc < 100) begin
        exp = (cyc < 90);
        checks++;
        if (sq[1] !== exp) begin
          errors++;
          $display("FAIL load_sq1 cyc %0d got %b want %b", cyc, sq[1], exp);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    set_idle();
    do_reset();
    while (cyc < 90) begin
      if (cyc == 15) begin
        div_val[7:0] = 8'd0;
        div_load     = 2'b01;
      end else begin
        div_load = 2'b00;
      end
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL zero_model cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
      if (cyc >= 40) begin
        checks++;
        if ({tick[0], sq[0]} !== {base_tick, 1'b1} ||
            base_tick !== (cyc % 10 == 0)) begin
          errors++;
          $display("FAIL zero_div1 cyc %0d got tick0 %b sq0 %b base %b",
                   cyc, tick[0], sq[0], base_tick);
        end
      end
    end
  endtask

  task automatic test_ch_dis();
    set_idle();
    do_reset();
    while (cyc < 70) begin
      if (cyc == 12) ch_en[0] = 1'b0;
      if (cyc == 37) ch_en[0] = 1'b1;
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL chdis_model cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
      checks++;
      if (tick[0] !== (cyc == 60)) begin
        errors++;
        $display("FAIL chdis_tick0 cyc %0d got %b", cyc, tick[0]);
      end
    end
  endtask

  task automatic test_enable();
    set_idle();
    do_reset();
    while (cyc < 50) begin
      if (cyc == 13) enable = 1'b0;
      if (cyc == 28) enable = 1'b1;
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL enable_model cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
      checks++;
      if (base_tick !== (cyc == 10 || cyc == 35 || cyc == 45)) begin
        errors++;
        $display("FAIL enable_base cyc %0d got %b", cyc, base_tick);
      end
    end
  endtask

  task automatic test_sync_clr();
    set_idle();
    do_reset();
    while (cyc < 80) begin
      sync_clr = 1'b0;
      div_load = 2'b00;
      if (cyc == 37) begin
        sync_clr     = 1'b1;
        div_val[7:0] = 8'd2;
        div_load     = 2'b01;
      end
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL clr_model cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
      if (cyc == 38) begin
        checks++;
        if ({base_tick, tick, sq} !== 5'b0) begin
          errors++;
          $display("FAIL clr_zero got %b want 00000", {base_tick, tick, sq});
        end
      end
      if (cyc >= 38) begin
        checks++;
        if ({base_tick, tick[0]} !==
            {(cyc == 48 || cyc == 58 || cyc == 68 || cyc == 78),
             (cyc == 58 || cyc == 78)}) begin
          errors++;
          $display("FAIL clr_timing cyc %0d got base %b tick0 %b",
                   cyc, base_tick, tick[0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    set_idle();
    do_reset();
    while (cyc < 65) begin
      if (cyc == 5) begin
        div_val[7:0] = 8'd2;
        div_load     = 2'b01;
      end else begin
        div_load = 2'b00;
      end
      step();
    end
    checks++;
    if (sq[0] !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre_sq0 got %b want 1", sq[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({base_tick, tick, sq} !== 5'b0) begin
      errors++;
      $display("FAIL arst_async got %b want 00000", {base_tick, tick, sq});
    end
    do_reset();
    while (cyc < 85) begin
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL arst_model cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
      checks++;
      if (tick[0] !== (cyc == 40 || cyc == 80)) begin
        errors++;
        $display("FAIL arst_div4 cyc %0d got %b", cyc, tick[0]);
      end
    end
  endtask

  task automatic test_random();
    set_idle();
    do_reset();
    repeat (3000) begin
      enable   = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NCH; i++) begin
        ch_en[i]    = ($urandom_range(0, 7) != 0);
        div_load[i] = ($urandom_range(0, 24) == 0);
        div_val[i*DW +: DW] = DW'($urandom_range(0, 6));
      end
      step();
      checks++;
      if ({base_tick, tick, sq} !== {m_base, m_tick, m_sq}) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b",
                 cyc, {base_tick, tick, sq}, {m_base, m_tick, m_sq});
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    test_reset();
    test_default();
    test_load_mid();
    test_div_zero();
    test_ch_dis();
    test_enable();
    test_sync_clr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
